// File: rtl/pipe_fetch_elastic_pkg.sv
// Shared types for the fetch-to-decode stage.
// Stage states, payload layout, default NOP.
package pipe_pkg;

  localparam int FD_XLEN = 32;
  localparam int FD_ILEN = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [FD_ILEN-1:0] inst;
    logic [FD_XLEN-1:0] pc;
    logic [FD_XLEN-1:0] pc_plus_4;
  } fd_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_fetch_elastic_if.sv
// Fetch/decode handshake bundle for the IF/ID stage.
// slave = stage view, master = fetch+decode environment view.
interface pipe_fetch_elastic_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) ();

  logic            valid_f;
  logic            ready_f;
  logic [ILEN-1:0] inst_f;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_plus_4_f;

  logic            valid_d;
  logic            ready_d;
  logic [ILEN-1:0] inst_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus_4_d;

  modport master (
    output valid_f, inst_f, pc_f, pc_plus_4_f, ready_d,
    input  ready_f, valid_d, inst_d, pc_d, pc_plus_4_d
  );

  modport slave (
    input  valid_f, inst_f, pc_f, pc_plus_4_f, ready_d,
    output ready_f, valid_d, inst_d, pc_d, pc_plus_4_d
  );

endinterface

// File: rtl/pipe_fetch_elastic_reg.sv
// Width-generic elastic register: main slot plus optional skid slot.
// Flush empties both slots and drops the beat offered that cycle.
module pipe_elastic_reg
  import pipe_pkg::*;
#(
  parameter int W       = 96,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  stage_state_e state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         rdy_q;
  logic         in_fire, out_fire;
  logic         ld_main_in, ld_main_skid, ld_skid;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = SKID_EN ? rdy_q
                             : (out_ready || !out_valid);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next-state and slot-load decode; flush overrides all handshakes.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = FULL;
          ld_main_in = 1'b1;
        end
      end
      FULL: begin
        unique case (1'b1)
          in_fire && out_fire: ld_main_in = 1'b1;
          in_fire && !out_fire: begin
            if (SKID_EN) begin
              state_d = SKID;
              ld_skid = 1'b1;
            end
          end
          !in_fire && out_fire: state_d = EMPTY;
          default: ;
        endcase
      end
      SKID: begin
        if (out_fire) begin
          state_d      = FULL;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // State and registered ready (high unless heading into SKID).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != SKID);
    end
  end

  // Payload slots; contents are only meaningful while occupied.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)   main_q <= in_data;
      if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= in_data;
    end
  end

endmodule

// File: rtl/pipe_fetch_elastic.sv
// Elastic, flushable IF/ID stage.
// Packs inst/pc/pc+4 and shows a NOP bubble while empty.
module pipe_fetch_elastic #(
  parameter int               XLEN     = 32,
  parameter int               ILEN     = 32,
  parameter logic [ILEN-1:0]  NOP_INST = pipe_pkg::NOP_INST,
  parameter bit               SKID_EN  = 1'b1
) (
  input logic                 clk,
  input logic                 reset_n,
  input logic                 flush,
  pipe_fetch_elastic_if.slave bus
);

  localparam int PW = ILEN + 2 * XLEN;

  logic [PW-1:0] in_data, out_data;
  logic          out_valid;
  logic          in_ready;

  // Layout matches fd_payload_t: inst, pc, pc_plus_4.
  assign in_data = {bus.inst_f, bus.pc_f, bus.pc_plus_4_f};

  pipe_elastic_reg #(
    .W       (PW),
    .SKID_EN (SKID_EN)
  ) u_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (bus.valid_f),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (bus.ready_d),
    .out_data  (out_data)
  );

  assign bus.ready_f = in_ready;
  assign bus.valid_d = out_valid;

  // Bubble substitution: NOP and zero PCs when nothing is held.
  always_comb begin
    bus.inst_d      = NOP_INST;
    bus.pc_d        = '0;
    bus.pc_plus_4_d = '0;
    if (out_valid) begin
      bus.inst_d      = out_data[PW-1 -: ILEN];
      bus.pc_d        = out_data[2*XLEN-1 -: XLEN];
      bus.pc_plus_4_d = out_data[XLEN-1:0];
    end
  end

endmodule

// File: doc/pipe_fetch_elastic.md
# pipe_fetch_elastic

Parametrised fetch-to-decode pipeline stage that replaces the fixed IF/ID register with an elastic, flushable stage. It carries instruction, PC and PC+4 from fetch to decode under a valid/ready handshake, absorbs one-cycle decode back-pressure in a skid slot, and inserts a NOP bubble on flush (branch/jump redirect). It sits between the fetch unit and the decoder and is driven by the hazard unit's flush signal.

## Interface
Parameters:
- XLEN, 32, width of pc and pc_plus_4 fields
- ILEN, 32, instruction width
- NOP_INST, 32'h0000_0013, instruction presented on inst_d while the stage is empty (addi x0,x0,0)
- SKID_EN, 1, 1 = two-entry elastic stage with registered ready_f; 0 = single-entry stage with combinational ready_f

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- flush  in  1  kill stage contents and any beat offered this cycle
- valid_f  in  1  fetch offers a beat
- ready_f  out  1  stage can accept a beat
- inst_f  in  ILEN  fetched instruction
- pc_f  in  XLEN  PC of inst_f
- pc_plus_4_f  in  XLEN  PC+4 of inst_f
- valid_d  out  1  decode-side beat valid
- ready_d  in  1  decoder accepts beat
- inst_d  out  ILEN  instruction to decode
- pc_d  out  XLEN  PC to decode
- pc_plus_4_d  out  XLEN  PC+4 to decode

## Operation
- Upstream transfer: valid_f && ready_f at a rising edge. Downstream transfer: valid_d && ready_d at a rising edge.
- Storage: main slot (drives *_d outputs) and, when SKID_EN=1, one skid slot. Beat order is always preserved.
- States (SKID_EN=1): EMPTY (no beats), FULL (main only), SKID (main + skid).
  - EMPTY: in -> FULL, main <= input.
  - FULL: in && out -> FULL, main <= input; in && !out -> SKID, skid <= input; !in && out -> EMPTY.
  - SKID: no upstream acceptance; out -> FULL, main <= skid; else hold.
- ready_f (SKID_EN=1) = registered, high in EMPTY and FULL, low in SKID.
- SKID_EN=0: states EMPTY/FULL only; ready_f = ready_d || !valid_d (combinational).
- Empty outputs: whenever valid_d=0, inst_d=NOP_INST, pc_d=0, pc_plus_4_d=0.
- Flush: priority below reset, above all handshake activity. Next state EMPTY, skid cleared, beat offered in the flush cycle is discarded even if ready_f=1. A downstream transfer in the flush cycle still counts as completed.
- Reset: next edge with reset_n=0 forces EMPTY regardless of flush/valid_f; reset mid-SKID discards both beats.
- Reset values: valid_d=0, ready_f=1 (both modes, since stage empty), inst_d=NOP_INST, pc_d=0, pc_plus_4_d=0.
- No arithmetic; pc_plus_4 is carried, not computed.

## Timing
- Latency: beat accepted at edge N appears on *_d after edge N (one cycle).
- Throughput: one beat per cycle while ready_d=1.
- ready_f (SKID_EN=1) depends only on state, never on ready_d in the same cycle.
- ready_d falling with stage FULL and valid_f=1: that cycle's beat goes to skid; ready_f low from next cycle.
- Flush effect visible the cycle after assertion: valid_d=0, inst_d=NOP_INST, ready_f=1.

## Structure
- Shared package pipe_pkg: NOP_INST constant, typedef fd_payload_t (inst, pc, pc_plus_4), stage state enum (EMPTY, FULL, SKID).
- One natural sub-module: pipe_elastic_reg, a payload-width-generic two-slot elastic register with flush; pipe_fetch_elastic wraps it with the fd_payload_t packing and NOP substitution.

## Test plan
- Reset: hold reset_n=0 two cycles with valid_f=1 -> valid_d=0, inst_d=32'h13, pc_d=0, ready_f=1 after release.
- Streaming: pc_f=0x0,0x4,0x8 on consecutive cycles, ready_d=1 -> same pcs on pc_d one cycle later each, no gaps.
- Back-pressure (SKID_EN=1): ready_d low for 3 cycles while streaming 0x10,0x14,0x18 -> 0x10 held on pc_d, 0x14 in skid, ready_f=0, 0x18 re-offered by fetch; after ready_d=1 order 0x10,0x14,0x18 with no loss/duplication.
- Flush in SKID: flush=1 with two beats held and valid_f=1 (pc_f=0x40) -> next cycle valid_d=0, inst_d=32'h13, ready_f=1; 0x40 never appears.
- Flush vs reset: reset_n=0 and flush=1 same edge -> reset values; flush with ready_d=1 and valid_d=1 -> downstream beat counted once.
- SKID_EN=0: ready_d=0 while FULL -> ready_f=0 same cycle; ready_d=1 with valid_f=1 -> back-to-back transfer.
